// File: rtl/ecc_wr_pkg.sv
// Shared widths and the FIFO entry layout for the ECC write-path controller.
package ecc_wr_pkg;

  localparam int ECC_DW = 64;  // data bits
  localparam int ECC_CW = 8;   // check bits
  localparam int ECC_WW = 72;  // stored word: {chk, data}
  localparam int ECC_AW = 10;  // RAM address width carried with each entry

  // One queued RAM write: where it goes and the encoded word.
  typedef struct packed {
    logic [ECC_AW-1:0] addr;
    logic [ECC_CW-1:0] chk;
    logic [ECC_DW-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/ecc_wr_fifo.sv
// Circular buffer of encoded RAM writes with a registered occupancy count.
// Head entry is presented combinationally; a push that meets a full buffer
// (with no simultaneous pop) is dropped and latches a sticky overflow flag.
module ecc_wr_fifo
  import ecc_wr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       ecc_clk,
  input  logic                       ecc_reset,
  input  logic                       i_push,
  input  fifo_entry_t                i_entry,
  input  logic                       i_pop,
  output fifo_entry_t                o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt,
  output logic                       o_empty,
  output logic                       o_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fifo_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A full buffer still takes a push when the head leaves on the same edge.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  assign o_head = r_mem[r_rptr];
  assign o_cnt  = r_cnt;
  assign o_ovf  = r_ovf;

  // Pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge ecc_clk or posedge ecc_reset) begin
    if (ecc_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (i_push & ~w_do_push) r_ovf <= 1'b1;
    end
  end

  // Storage write; contents are qualified by the count, so no reset needed.
  // NOTE: the entry array is deliberately left out of reset so it can map to
  // plain RAM/flops without a reset tree; stale entries are never read.
  always_ff @(posedge ecc_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_entry;
  end

endmodule

// File: rtl/ecc_wr_ctrl_64x8.sv
// Write-path controller around a 2-stage, clock-enabled 64/8 ECC encoder.
// Requests are fed to the encoder, a shadow valid/address pipe tracks them in
// lockstep, and finished words queue in a credit-protected FIFO toward RAM.
module ecc_wr_ctrl_64x8
  import ecc_wr_pkg::*;
#(
  parameter int AW         = ECC_AW,
  parameter int ENC_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                ecc_clk,
  input  logic                ecc_reset,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [AW-1:0]       in_addr,
  input  logic [ECC_DW-1:0]   in_data,
  output logic                enc_clken,
  output logic [ECC_DW-1:0]   enc_data_in,
  input  logic [ECC_DW-1:0]   enc_data_out,
  input  logic [ECC_CW-1:0]   enc_chkbits,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [ECC_WW-1:0]   mem_wdata,
  input  logic                mem_rdy,
  output logic [31:0]         wr_cnt,
  output logic                ovf_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(FIFO_DEPTH + ENC_LAT + 1) + 1;

  logic [ENC_LAT:1] r_vld;
  logic [AW-1:0]    r_addr [1:ENC_LAT];
  logic [31:0]      r_wr_cnt;

  logic [CW-1:0] w_fifo_cnt;
  logic          w_fifo_empty;
  logic          w_pop;
  logic          w_push;
  logic [TW-1:0] w_total;
  fifo_entry_t   w_wr_entry;
  fifo_entry_t   w_head;

  // Credits in use: queued words plus every word still inside the encoder.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments and gives every
    // output a value before any loop/branch, which keeps it latch-free.
    w_total = TW'(w_fifo_cnt);
    for (int k = 1; k <= ENC_LAT; k++) begin
      w_total = w_total + TW'(r_vld[k]);
    end
  end

  // The encoder only advances when the FIFO can absorb everything in flight,
  // counting a word that leaves this cycle as already freed.
  assign w_pop       = mem_we & mem_rdy;
  assign enc_clken   = (w_total - TW'(w_pop)) < TW'(FIFO_DEPTH);
  assign in_rdy      = enc_clken;
  assign enc_data_in = in_data;

  // Shadow valid/address pipe, held whenever the encoder is held.
  always_ff @(posedge ecc_clk or posedge ecc_reset) begin
    if (ecc_reset) begin
      r_vld <= '0;
      for (int k = 1; k <= ENC_LAT; k++) r_addr[k] <= '0;
    end else if (enc_clken) begin
      r_vld[1]  <= in_vld & in_rdy;
      r_addr[1] <= in_addr;
      for (int k = 2; k <= ENC_LAT; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_addr[k] <= r_addr[k-1];
      end
    end
  end

  assign w_push           = enc_clken & r_vld[ENC_LAT];
  assign w_wr_entry.addr  = r_addr[ENC_LAT];
  assign w_wr_entry.chk   = enc_chkbits;
  assign w_wr_entry.data  = enc_data_out;

  ecc_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ecc_clk   (ecc_clk),
    .ecc_reset (ecc_reset),
    .i_push    (w_push),
    .i_entry   (w_wr_entry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_cnt     (w_fifo_cnt),
    .o_empty   (w_fifo_empty),
    .o_ovf     (ovf_err)
  );

  assign mem_we    = ~w_fifo_empty;
  assign mem_addr  = w_head.addr;
  assign mem_wdata = {w_head.chk, w_head.data};

  // Completed RAM writes, free-running modulo 2^32.
  always_ff @(posedge ecc_clk or posedge ecc_reset) begin
    if (ecc_reset) r_wr_cnt <= '0;
    else if (w_pop) r_wr_cnt <= r_wr_cnt + 32'd1;
  end

  assign wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_ecc_wr_ctrl_64x8.sv
// Directed bench for ecc_wr_ctrl_64x8 with a behavioural 2-stage encoder and
// an in-order scoreboard on the RAM write port.
module tb_ecc_wr_ctrl_64x8;

  logic        ecc_clk = 1'b0;
  logic        ecc_reset = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [9:0]  in_addr = '0;
  logic [63:0] in_data = '0;
  logic        enc_clken;
  logic [63:0] enc_data_in;
  logic [63:0] enc_data_out;
  logic [7:0]  enc_chkbits;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [71:0] mem_wdata;
  logic        mem_rdy = 1'b0;
  logic [31:0] wr_cnt;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_wr_cnt = '0;

  always #5 ecc_clk = ~ecc_clk;

  ecc_wr_ctrl_64x8 dut (
    .ecc_clk      (ecc_clk),
    .ecc_reset    (ecc_reset),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .enc_clken    (enc_clken),
    .enc_data_in  (enc_data_in),
    .enc_data_out (enc_data_out),
    .enc_chkbits  (enc_chkbits),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdy      (mem_rdy),
    .wr_cnt       (wr_cnt),
    .ovf_err      (ovf_err)
  );

  // Reference check-bit function of the encoder model.
  function automatic logic [7:0] ref_chk(input logic [63:0] d);
    logic [7:0] c;
    logic [5:0] jj;
    c = '0;
    for (int j = 0; j < 64; j++) begin
      jj = 6'(j);
      for (int i = 0; i < 6; i++) if (jj[i]) c[i] = c[i] ^ d[j];
    end
    c[6] = ^d[31:0];
    c[7] = ^d;
    return c;
  endfunction

  // Encoder model: input register then output register, both clock-enabled.
  logic [63:0] enc_in_r, enc_out_r;
  logic [7:0]  enc_chk_r;
  always @(posedge ecc_clk or posedge ecc_reset) begin
    if (ecc_reset) begin
      enc_in_r  <= '0;
      enc_out_r <= '0;
      enc_chk_r <= '0;
    end else if (enc_clken) begin
      enc_in_r  <= enc_data_in;
      enc_out_r <= enc_in_r;
      enc_chk_r <= ref_chk(enc_in_r);
    end
  end
  assign enc_data_out = enc_out_r;
  assign enc_chkbits  = enc_chk_r;

  // Scoreboard: accepted requests in order, compared at each RAM write.
  typedef struct {
    logic [9:0]  addr;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t exp_e;
  bit          mon_en = 1'b0;
  int          mon_pops = 0;
  int          stall_cnt = 0;
  bit          hold_pend = 1'b0;
  logic [9:0]  hold_addr;
  logic [71:0] hold_wdata;

  always @(negedge ecc_clk) begin
    if (mon_en && !ecc_reset) begin
      if (in_vld && in_rdy) exp_q.push_back('{addr: in_addr, data: in_data});
      if (hold_pend) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== hold_addr || mem_wdata !== hold_wdata) begin
          errors++;
          $display("FAIL hold_stable: got we=%b addr=%h wdata=%h, need we=1 addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, hold_addr, hold_wdata);
        end
      end
      if (mem_we && mem_rdy) begin
        checks++;
        mon_pops++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got write addr=%h with nothing outstanding", mem_addr);
        end else begin
          exp_e = exp_q.pop_front();
          if (mem_addr !== exp_e.addr || mem_wdata !== {ref_chk(exp_e.data), exp_e.data}) begin
            errors++;
            $display("FAIL sb_order: got addr=%h wdata=%h, need addr=%h wdata=%h",
                     mem_addr, mem_wdata, exp_e.addr, {ref_chk(exp_e.data), exp_e.data});
          end
        end
      end
      if (mem_we && !mem_rdy) stall_cnt++;
      hold_pend  = mem_we && !mem_rdy;
      hold_addr  = mem_addr;
      hold_wdata = mem_wdata;
    end
  end

  task automatic next_cycle();
    @(posedge ecc_clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    ecc_reset = 1'b1;
    in_vld    = 1'b0;
    mem_rdy   = 1'b0;
    in_data   = 64'hDEAD_BEEF_CAFE_F00D;
    repeat (2) @(posedge ecc_clk);
    #1;
    ecc_reset = 1'b0;
    @(negedge ecc_clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b need 0", mem_we); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL rst_wr_cnt: got %0d need 0", wr_cnt); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b need 0", ovf_err); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy: got %b need 1", in_rdy); end
    checks++; if (enc_clken !== 1'b1) begin errors++; $display("FAIL rst_clken: got %b need 1", enc_clken); end
    checks++; if (enc_data_in !== 64'hDEAD_BEEF_CAFE_F00D) begin
      errors++; $display("FAIL enc_data_in: got %h need deadbeefcafef00d", enc_data_in);
    end
    next_cycle();
    exp_wr_cnt = 32'd0;
  endtask

  task automatic test_single();
    logic [63:0] d;
    d       = 64'h0123_4567_89AB_CDEF;
    mon_en  = 1'b1;
    mem_rdy = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_vld  = (c == 0);
      in_addr = 10'h005;
      in_data = d;
      @(negedge ecc_clk);
      if (c == 0) begin
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b need 1", in_rdy); end
      end
      checks++;
      if (mem_we !== (c == 3)) begin
        errors++; $display("FAIL single_we c%0d: got %b need %b", c, mem_we, (c == 3));
      end
      if (c == 3) begin
        checks++; if (mem_addr !== 10'h005) begin errors++; $display("FAIL single_addr: got %h need 005", mem_addr); end
        checks++; if (mem_wdata[63:0] !== d) begin errors++; $display("FAIL single_data: got %h need %h", mem_wdata[63:0], d); end
        checks++; if (mem_wdata[71:64] !== ref_chk(d)) begin
          errors++; $display("FAIL single_chk: got %h need %h", mem_wdata[71:64], ref_chk(d));
        end
      end
      next_cycle();
    end
    exp_wr_cnt = 32'd1;
    checks++; if (wr_cnt !== exp_wr_cnt) begin errors++; $display("FAIL single_cnt: got %0d need %0d", wr_cnt, exp_wr_cnt); end
  endtask

  task automatic test_back_to_back();
    mem_rdy = 1'b1;
    for (int c = 0; c < 22; c++) begin
      in_vld  = (c < 16);
      in_addr = 10'(c);
      in_data = {32'hA5A5_0000 + 32'(c), 32'h5A5A_0000 + 32'(c)};
      @(negedge ecc_clk);
      if (c < 16) begin
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy c%0d: got %b need 1", c, in_rdy); end
      end
      checks++;
      if (mem_we !== (c >= 3 && c < 19)) begin
        errors++; $display("FAIL b2b_we c%0d: got %b need %b", c, mem_we, (c >= 3 && c < 19));
      end
      if (c >= 3 && c < 19) begin
        checks++;
        if (mem_addr !== 10'(c - 3)) begin errors++; $display("FAIL b2b_addr c%0d: got %h need %h", c, mem_addr, 10'(c - 3)); end
      end
      next_cycle();
    end
    exp_wr_cnt = exp_wr_cnt + 32'd16;
    checks++; if (wr_cnt !== exp_wr_cnt) begin errors++; $display("FAIL b2b_cnt: got %0d need %0d", wr_cnt, exp_wr_cnt); end
  endtask

  task automatic test_backpressure();
    int  idx;
    int  acc;
    bit  took;
    idx     = 0;
    acc     = 0;
    mem_rdy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_vld  = 1'b1;
      in_addr = 10'h100 + 10'(idx);
      in_data = 64'h0BAD_0000_0000_0000 + 64'(idx);
      @(negedge ecc_clk);
      took = in_rdy;
      checks++; if (in_rdy !== (c < 4)) begin errors++; $display("FAIL bp_rdy c%0d: got %b need %b", c, in_rdy, (c < 4)); end
      checks++; if (enc_clken !== (c < 4)) begin errors++; $display("FAIL bp_clken c%0d: got %b need %b", c, enc_clken, (c < 4)); end
      checks++; if (mem_we !== (c >= 3)) begin errors++; $display("FAIL bp_we c%0d: got %b need %b", c, mem_we, (c >= 3)); end
      next_cycle();
      if (took) begin idx++; acc++; end
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d need 4", acc); end
    in_vld  = 1'b0;
    mem_rdy = 1'b1;
    for (int d = 0; d < 5; d++) begin
      @(negedge ecc_clk);
      checks++; if (mem_we !== (d < 4)) begin errors++; $display("FAIL bp_drain_we d%0d: got %b need %b", d, mem_we, (d < 4)); end
      if (d < 4) begin
        checks++;
        if (mem_addr !== 10'h100 + 10'(d)) begin errors++; $display("FAIL bp_drain_addr d%0d: got %h need %h", d, mem_addr, 10'h100 + 10'(d)); end
      end
      next_cycle();
    end
    in_vld  = 1'b1;
    in_addr = 10'h104;
    in_data = 64'h0BAD_0000_0000_0004;
    @(negedge ecc_clk);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b need 1", in_rdy); end
    next_cycle();
    idle(5);
    exp_wr_cnt = exp_wr_cnt + 32'd5;
    checks++; if (wr_cnt !== exp_wr_cnt) begin errors++; $display("FAIL bp_cnt: got %0d need %0d", wr_cnt, exp_wr_cnt); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL bp_ovf: got %b need 0", ovf_err); end
  endtask

  task automatic test_alternating();
    int  sent;
    int  base;
    int  c;
    bit  took;
    sent = 0;
    base = mon_pops;
    c    = 0;
    while ((sent < 12 || mon_pops - base < 12) && c < 200) begin
      mem_rdy = ((c / 3) % 2 == 0);
      in_vld  = (sent < 12) && (c % 2 == 0);
      in_addr = 10'h200 + 10'(sent);
      in_data = 64'hF0F0_0000_1111_0000 ^ (64'(sent) << 20);
      @(negedge ecc_clk);
      took = in_vld && in_rdy;
      next_cycle();
      if (took) sent++;
      c++;
    end
    in_vld  = 1'b0;
    mem_rdy = 1'b1;
    checks++; if (sent != 12) begin errors++; $display("FAIL alt_sent: got %0d need 12", sent); end
    checks++; if (mon_pops - base != 12) begin errors++; $display("FAIL alt_writes: got %0d need 12", mon_pops - base); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL alt_leftover: got %0d need 0", exp_q.size()); end
    idle(2);
    exp_wr_cnt = exp_wr_cnt + 32'd12;
    checks++; if (wr_cnt !== exp_wr_cnt) begin errors++; $display("FAIL alt_cnt: got %0d need %0d", wr_cnt, exp_wr_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] d;
    mem_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_vld  = 1'b1;
      in_addr = 10'h030 + 10'(c);
      in_data = 64'h7777_0000_0000_0000 + 64'(c);
      next_cycle();
    end
    in_vld = 1'b0;
    @(negedge ecc_clk);
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_pre_we: got %b need 1", mem_we); end
    mon_en    = 1'b0;
    ecc_reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b need 0", mem_we); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d need 0", wr_cnt); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_rdy: got %b need 1", in_rdy); end
    exp_q.delete();
    hold_pend = 1'b0;
    next_cycle();
    ecc_reset  = 1'b0;
    mon_en     = 1'b1;
    exp_wr_cnt = 32'd0;
    d = 64'hFEDC_BA98_7654_3210;
    for (int c = 0; c < 6; c++) begin
      in_vld  = (c == 0);
      in_addr = 10'h3FF;
      in_data = d;
      @(negedge ecc_clk);
      checks++;
      if (mem_we !== (c == 3)) begin errors++; $display("FAIL mid_new_we c%0d: got %b need %b", c, mem_we, (c == 3)); end
      if (c == 3) begin
        checks++; if (mem_addr !== 10'h3FF) begin errors++; $display("FAIL mid_new_addr: got %h need 3ff", mem_addr); end
        checks++; if (mem_wdata !== {ref_chk(d), d}) begin
          errors++; $display("FAIL mid_new_wdata: got %h need %h", mem_wdata, {ref_chk(d), d});
        end
      end
      next_cycle();
    end
    exp_wr_cnt = 32'd1;
    checks++; if (wr_cnt !== exp_wr_cnt) begin errors++; $display("FAIL mid_cnt: got %0d need %0d", wr_cnt, exp_wr_cnt); end
  endtask

  task automatic test_wrap();
    int  sent;
    int  base;
    int  stalls0;
    int  c;
    bit  took;
    sent    = 0;
    base    = mon_pops;
    stalls0 = stall_cnt;
    c       = 0;
    while ((sent < 9 || mon_pops - base < 9) && c < 200) begin
      mem_rdy = ((c % 12) >= 6);
      in_vld  = (sent < 9);
      in_addr = 10'h2C0 + 10'(sent);
      in_data = {32'(sent) * 32'h0101_0101, 32'hC3C3_C3C3};
      @(negedge ecc_clk);
      took = in_vld && in_rdy;
      next_cycle();
      if (took) sent++;
      c++;
    end
    in_vld  = 1'b0;
    mem_rdy = 1'b1;
    checks++; if (sent != 9) begin errors++; $display("FAIL wrap_sent: got %0d need 9", sent); end
    checks++; if (mon_pops - base != 9) begin errors++; $display("FAIL wrap_writes: got %0d need 9", mon_pops - base); end
    checks++; if (stall_cnt == stalls0) begin errors++; $display("FAIL wrap_stall: got 0 stalled cycles need >0"); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_leftover: got %0d need 0", exp_q.size()); end
    idle(2);
    exp_wr_cnt = exp_wr_cnt + 32'd9;
    checks++; if (wr_cnt !== exp_wr_cnt) begin errors++; $display("FAIL wrap_cnt: got %0d need %0d", wr_cnt, exp_wr_cnt); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b need 0", ovf_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_alternating();
    test_reset_mid_burst();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_wr_ctrl_64x8.md
Name: ecc_wr_ctrl_64x8

Overview:
Write-path controller downstream of the 64-bit / 8-check-bit ECC encoder (input and output registered, clock-enabled, 2 enable-qualified cycles of latency). It accepts write requests (address plus 64-bit data) on a valid/ready handshake and drives the encoder data input and clock enable. A shadow valid/address pipeline is kept aligned with the encoder latency. Encoded words are collected as 72-bit {chkbits, data} into a small credit-protected FIFO, which issues writes to the ECC-protected RAM with backpressure.

Parameters:
AW, 10, RAM address width
ENC_LAT, 2, encoder latency in enable-qualified cycles (matches encoder: input reg + output reg)
FIFO_DEPTH, 4, output FIFO entries; must be >= ENC_LAT+2 (power of 2)

Ports:
ecc_clk  in  1  clock
ecc_reset  in  1  asynchronous active-high reset
in_vld  in  1  write request valid
in_rdy  out  1  request accepted when in_vld & in_rdy
in_addr  in  AW  write address
in_data  in  64  write data
enc_clken  out  1  to encoder clock enable
enc_data_in  out  64  to encoder data input
enc_data_out  in  64  from encoder data output
enc_chkbits  in  8  from encoder check-bit output
mem_we  out  1  RAM write request (FIFO non-empty)
mem_addr  out  AW  RAM write address
mem_wdata  out  72  {chkbits[7:0], data[63:0]}
mem_rdy  in  1  RAM accepts write when mem_we & mem_rdy
wr_cnt  out  32  count of completed RAM writes
ovf_err  out  1  sticky: push attempted with FIFO full (must never fire)

Behaviour:
- Reset (async, active-high): all shadow valids 0, FIFO empty, wr_cnt 0, ovf_err 0, mem_we 0. in_rdy and enc_clken = 1 after reset (credits free). In-flight data is discarded; the encoder is reset by the same ecc_reset.
- pop = mem_we & mem_rdy. total = fifo_cnt + sum(shadow vld[1..ENC_LAT]).
- enc_clken = (total - pop) < FIFO_DEPTH (combinational). in_rdy = enc_clken.
- enc_data_in = in_data (combinational). The encoder registers it on an enabled edge.
- Shadow pipe: on an edge with enc_clken=1: vld[1] <= in_vld & in_rdy, addr[1] <= in_addr, and vld[k] <= vld[k-1] for k>1. With enc_clken=0 the pipe holds, in lockstep with the encoder. Bubbles (in_vld=0) enter as vld=0.
- Push: on an edge with enc_clken & vld[ENC_LAT], write {enc_chkbits, enc_data_out, addr[ENC_LAT]} into the FIFO.
- The FIFO is a circular buffer with a registered count. Output is the head entry, combinational. mem_we = (fifo_cnt != 0).
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- Invariant: total <= FIFO_DEPTH, so a push never meets a full FIFO. If it does, set ovf_err, drop the word and keep the count unchanged.
- wr_cnt increments on each pop and wraps at 2^32.
- Latency: accept in cycle 0 (ENC_LAT=2) -> push at end of cycle 2 -> mem_we=1 in cycle 3 with the matching word.
- Throughput: 1 write/cycle sustained when mem_rdy=1. mem_rdy=0 fills credits, after which in_rdy=0. No deadlock: in-flight words always have FIFO space.
- Ordering: strictly in acceptance order. mem_addr/mem_wdata stay stable while mem_we=1 & mem_rdy=0.

Decomposition:
- Package ecc_wr_pkg: ECC_DW=64, ECC_CW=8, ECC_WW=72, and a packed struct typedef for the FIFO entry {addr, chk, data}.
- One sub-module, ecc_wr_fifo: the parameterised circular FIFO with count, full/empty and overflow flag.
- Shadow pipe and credit logic stay in the top level.

Test Plan:
- Single write addr=0x005, data=0x0123456789ABCDEF, mem_rdy=1 -> mem_we high in cycle 3 only; mem_addr=0x005; mem_wdata[63:0]=data; mem_wdata[71:64] equals the encoder reference check bits; wr_cnt=1.
- Back-to-back 16 writes, addr 0..15, mem_rdy=1 -> in_rdy stays 1; 16 consecutive mem_we cycles starting cycle 3; addresses in order; wr_cnt=16.
- mem_rdy=0 with continuous in_vld -> exactly FIFO_DEPTH=4 requests accepted, then in_rdy=0 and enc_clken=0. Release mem_rdy -> 4 writes drain in order, then acceptance resumes; ovf_err stays 0.
- Alternating in_vld 1/0 with mem_rdy toggling every 3 cycles -> output sequence equals input sequence (scoreboard), no duplicates or losses.
- Assert ecc_reset mid-burst with 3 words in flight -> mem_we=0 and wr_cnt=0 immediately (async); after release, a new write addr=0x3FF appears 3 cycles after acceptance with correct data.
- FIFO pointer wrap: 9 writes with a mem_rdy stall pattern forcing full/empty cycles -> all 9 written in order; mem_wdata held stable during stalls.
